// File: rtl/shift_reg_pkg.sv
// Shared mode encoding and sizing helpers for the universal shift register.
package shift_reg_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

    // Bits needed to hold a count from 0 up to and including width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// Counts shifts remaining in a loaded frame; raises busy and a one-cycle frame_done pulse.
module shift_frame_counter
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic shift,
    output logic busy,
    output logic frame_done
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // load and shift arrive already qualified by en, so idle cycles simply clear the pulse.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (load) begin
            cnt_d  = CntLoad;
            busy_d = 1'b1;
        end else if (shift && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntOne;
            if (cnt_q == CntOne) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: rtl/shift_reg_universal.sv
// Parametrised universal shift register: hold, shift right/left and parallel load with frame tracking.
module shift_reg_universal
    import shift_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             frame_done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             do_load;
    logic             do_shift;

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                MODE_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
                MODE_LOAD: q_d = pin;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // Both directions count toward the frame, so a mid-frame direction change is harmless.
    assign do_load  = en && (mode == MODE_LOAD);
    assign do_shift = en && ((mode == MODE_SHR) || (mode == MODE_SHL));

    shift_frame_counter #(
        .WIDTH(WIDTH)
    ) u_frame_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (do_load),
        .shift     (do_shift),
        .busy      (busy),
        .frame_done(frame_done)
    );

    assign pout   = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Randomised bench for shift_reg_universal against an arithmetic reference model.
module tb_shift_reg_universal;

    localparam int W = 4;
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] SHR  = 2'b01;
    localparam logic [1:0] SHL  = 2'b10;
    localparam logic [1:0] LOAD = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = HOLD;
    logic         sin_r = 1'b0;
    logic         sin_l = 1'b0;
    logic [W-1:0] pin = '0;
    logic [W-1:0] pout;
    logic         sout_r;
    logic         sout_l;
    logic         busy;
    logic         frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: register value as an integer plus shifts left in the frame.
    int unsigned m_q    = 0;
    int          m_rem  = 0;
    bit          m_done = 1'b0;

    shift_reg_universal #(
        .WIDTH    (W),
        .RESET_VAL(4'h0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .pin       (pin),
        .pout      (pout),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int unsigned mask;
        mask = (1 << W) - 1;
        if (!rst_n) begin
            m_q = 0;
            m_rem = 0;
            m_done = 1'b0;
        end else if (!en) begin
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (mode == SHR || mode == SHL) begin
                if (mode == SHR) m_q = (m_q >> 1) | (int'(sin_r) << (W - 1));
                else             m_q = ((m_q << 1) | int'(sin_l)) & mask;
                if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) m_done = 1'b1;
                end
            end else if (mode == LOAD) begin
                m_q = int'(pin);
                m_rem = W;
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [1:0] m, input bit sr,
                        input bit sl, input logic [W-1:0] p);
        rst_n = r;
        en = e;
        mode = m;
        sin_r = sr;
        sin_l = sl;
        pin = p;
        @(posedge clk);
        model_edge();
        #1;
        check("pout", 64'(pout), 64'(m_q));
        check("sout_r", 64'(sout_r), 64'(m_q & 1));
        check("sout_l", 64'(sout_l), 64'((m_q >> (W - 1)) & 1));
        check("busy", 64'(busy), 64'(m_rem > 0));
        check("frame_done", 64'(frame_done), 64'(m_done));
    endtask

    initial begin
        logic [W-1:0] siso_exp [4];
        bit           siso_in  [4];
        bit           r, e, sr, sl;
        logic [1:0]   m;
        int           pick;

        siso_exp = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
        siso_in  = '{1'b1, 1'b0, 1'b1, 1'b1};

        @(negedge clk);
        // Reset beats a simultaneous load.
        step(0, 1, LOAD, 0, 0, 4'hF);
        check("rst_pri_pout", 64'(pout), 64'h0);
        check("rst_pri_busy", 64'(busy), 64'h0);
        step(1, 1, LOAD, 0, 0, 4'hF);
        check("load_after_rst", 64'(pout), 64'hF);

        // Plain SISO behaviour with no frame loaded.
        step(0, 1, HOLD, 0, 0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, SHR, siso_in[i], 0, 4'h0);
            check("siso_pout", 64'(pout), 64'(siso_exp[i]));
            check("siso_busy", 64'(busy), 64'h0);
            check("siso_done", 64'(frame_done), 64'h0);
        end

        // Load then serialise a full frame.
        step(1, 1, LOAD, 0, 0, 4'hA);
        for (int i = 0; i < 4; i++) begin
            check("ser_busy", 64'(busy), 64'h1);
            check("ser_sout", 64'(sout_r), 64'(i % 2));
            step(1, 1, SHR, 0, 0, 4'h0);
        end
        check("ser_done", 64'(frame_done), 64'h1);
        check("ser_pout", 64'(pout), 64'h0);
        step(1, 1, HOLD, 0, 0, 4'h0);
        check("ser_done_clr", 64'(frame_done), 64'h0);

        // Gated frame, then reload and reset mid-frame.
        step(1, 1, LOAD, 0, 0, 4'hA);
        step(1, 1, SHR, 0, 0, 4'h0);
        step(1, 1, SHR, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) step(1, 0, SHR, 1, 1, 4'hF);
        check("gate_pout", 64'(pout), 64'h2);
        step(1, 1, LOAD, 0, 0, 4'h5);
        for (int i = 0; i < 3; i++) step(1, 1, SHL, 1, 1, 4'h0);
        step(0, 1, SHR, 0, 0, 4'h0);
        step(1, 1, SHR, 0, 0, 4'h0);
        check("rst_mid_done", 64'(frame_done), 64'h0);

        // Randomised traffic, weighted toward shifts so frames regularly complete.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 39) != 0);
            e = ($urandom_range(0, 4) != 0);
            pick = int'($urandom_range(0, 9));
            if (pick == 0)      m = HOLD;
            else if (pick <= 4) m = SHR;
            else if (pick <= 8) m = SHL;
            else                m = LOAD;
            sr = 1'($urandom);
            sl = 1'($urandom);
            step(r, e, m, sr, sl, W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
- Parametrised universal shift register; next generation of the team's fixed 4-bit serial-in/serial-out shifter.
- Adds configurable width, four modes (hold, shift right, shift left, parallel load), enable and synchronous reset.
- Adds a frame counter that flags completion of WIDTH shifts after a parallel load.
- Serves as serializer/deserializer front end for serial links and bit-banged peripherals.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..64.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into the register on reset.

Ports:
- clk  input  1  rising-edge clock; sole clock domain.
- rst_n  input  1  synchronous reset, active-low.
- en  input  1  clock enable; when low, all state holds.
- mode  input  2  operation select; encoding given under Decomposition.
- sin_r  input  1  serial input entering at bit WIDTH-1 during shift right.
- sin_l  input  1  serial input entering at bit 0 during shift left.
- pin  input  WIDTH  parallel load data.
- pout  output  WIDTH  register contents q.
- sout_r  output  1  q[0]; serial output for shift right.
- sout_l  output  1  q[WIDTH-1]; serial output for shift left.
- busy  output  1  high while a loaded frame has shifts remaining.
- frame_done  output  1  one-cycle pulse marking completion of a frame.

Behaviour:
- All state updates on the rising edge of clk. Outputs are pure functions of registers (no combinational input-to-output paths).
- Reset (rst_n=0 at an edge, any mode, any en): q=RESET_VAL, cnt=0, busy=0, frame_done=0. Reset overrides en and mode. Reset mid-frame abandons the frame; no frame_done is produced.
- en=0: q, cnt and busy hold; frame_done is 0 on the next edge.
- en=1, per mode:
  - HOLD: q holds; cnt holds.
  - SHR: q <= {sin_r, q[WIDTH-1:1]}. Data enters at the MSB and moves toward bit 0, so a bit presented on sin_r appears on sout_r after exactly WIDTH edges (SISO-compatible).
  - SHL: q <= {q[WIDTH-2:0], sin_l}.
  - LOAD: q <= pin; cnt <= WIDTH; busy <= 1. A load while busy restarts the frame without issuing frame_done.
- Frame counter:
  - cnt is $clog2(WIDTH+1) bits; busy = (cnt != 0), implemented as a register.
  - Each SHR or SHL edge with cnt>0 decrements cnt.
  - On the edge where cnt goes 1->0: busy <= 0 and frame_done <= 1.
  - On every other edge, frame_done <= 0. frame_done is never high for two consecutive cycles.
  - Shifts with cnt=0 still move data; cnt stays 0 (no wrap-around, no underflow).
- Direction may change mid-frame; every shift counts regardless of direction.
- Latency: one edge from a qualifying input to its effect on pout, busy and frame_done.

Decomposition:
- Package shift_reg_pkg holds:
  - mode typedef and constants: MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - helper function cnt_width(WIDTH) returning $clog2(WIDTH+1).
- Optional sub-module shift_frame_counter (cnt, busy, frame_done). The datapath stays in the top module.

Test Plan (WIDTH=4, RESET_VAL=0):
- Reset priority: rst_n=0, en=1, mode=LOAD, pin=4'hF for 1 edge -> pout=4'h0, busy=0, frame_done=0; rst_n=1 -> next LOAD gives pout=4'hF.
- SISO compatibility: mode=SHR, no load, sin_r=1,0,1,1 on edges 1-4 -> pout=4'b1000, 0100, 1010, 1101; sout_r=0,0,0,1; busy stays 0; frame_done never asserts.
- Load and serialize: LOAD pin=4'hA, then 4 SHR with sin_r=0 -> sout_r=0,1,0,1 before each shift edge; busy=1 for 4 cycles; frame_done=1 exactly one cycle after the 4th shift; pout=4'h0.
- Shift left: LOAD 4'h3, 2 SHL with sin_l=1 -> pout=4'h7 then 4'hF; sout_l=0 then 1; busy remains 1 (cnt=2).
- Enable gating mid-frame: LOAD 4'hA, 2 SHR (sin_r=0) -> pout=4'h2; en=0 for 3 cycles -> pout=4'h2 and busy=1 held, frame_done=0; 2 more SHR -> frame_done pulses once.
- Reload and reset mid-frame: LOAD 4'hA, 2 SHR, LOAD 4'h5 -> no frame_done, cnt=4, 4 more shifts required; after 1 shift, rst_n=0 -> pout=0, busy=0, and no frame_done follows.
